// File: rtl/seven_segment_decoder.sv
// Recovers a hex digit from seven active-high segment lines once the pattern
// has been stable for STABLE_CYCLES edges; flags blank and illegal glyphs.
module seven_segment_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Segment_A,
    input  logic       i_Segment_B,
    input  logic       i_Segment_C,
    input  logic       i_Segment_D,
    input  logic       i_Segment_E,
    input  logic       i_Segment_F,
    input  logic       i_Segment_G,
    output logic [3:0] o_Binary_Num,
    output logic       o_Valid,
    output logic       o_Error,
    output logic       o_Blank
);

    localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

    typedef enum logic {
        LOCKED   = 1'b0,
        SETTLING = 1'b1
    } state_t;

    // Returns {legal, value}; blank and unknown patterns report legal=0.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] result;
        case (seg)
            7'b1111110: result = {1'b1, 4'h0};
            7'b0110000: result = {1'b1, 4'h1};
            7'b1101101: result = {1'b1, 4'h2};
            7'b1111001: result = {1'b1, 4'h3};
            7'b0110011: result = {1'b1, 4'h4};
            7'b1011011: result = {1'b1, 4'h5};
            7'b1011111: result = {1'b1, 4'h6};
            7'b1110000: result = {1'b1, 4'h7};
            7'b1111111: result = {1'b1, 4'h8};
            7'b1111011: result = {1'b1, 4'h9};
            7'b1110111: result = {1'b1, 4'hA};
            7'b0011111: result = {1'b1, 4'hB};
            7'b1001110: result = {1'b1, 4'hC};
            7'b0111101: result = {1'b1, 4'hD};
            7'b1001111: result = {1'b1, 4'hE};
            7'b1000111: result = {1'b1, 4'hF};
            default:    result = 5'b0_0000;
        endcase
        return result;
    endfunction

    state_t     r_State;
    logic [6:0] r_Seg;
    logic [7:0] r_Count;
    logic [3:0] r_Binary_Num;
    logic       r_Valid;
    logic       r_Error;
    logic       r_Blank;

    state_t     w_State_Next;
    logic [6:0] w_Seg_Next;
    logic [7:0] w_Count_Next;
    logic [3:0] w_Binary_Num_Next;
    logic       w_Valid_Next;
    logic       w_Error_Next;
    logic       w_Blank_Next;

    logic [6:0] w_Pattern;
    logic [4:0] w_Decoded;
    logic       w_Legal;
    logic [3:0] w_Value;

    assign w_Pattern = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                        i_Segment_E, i_Segment_F, i_Segment_G};
    assign w_Decoded = decode_glyph(r_Seg);
    assign w_Legal   = w_Decoded[4];
    assign w_Value   = w_Decoded[3:0];

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            r_State      <= LOCKED;
            r_Seg        <= 7'd0;
            r_Count      <= 8'd0;
            r_Binary_Num <= 4'd0;
            r_Valid      <= 1'b0;
            r_Error      <= 1'b0;
            r_Blank      <= 1'b1;
        end else begin
            r_State      <= w_State_Next;
            r_Seg        <= w_Seg_Next;
            r_Count      <= w_Count_Next;
            r_Binary_Num <= w_Binary_Num_Next;
            r_Valid      <= w_Valid_Next;
            r_Error      <= w_Error_Next;
            r_Blank      <= w_Blank_Next;
        end
    end

    // Any change reloads the held pattern, even on the edge that would accept.
    always_comb begin
        w_State_Next      = r_State;
        w_Seg_Next        = r_Seg;
        w_Count_Next      = r_Count;
        w_Binary_Num_Next = r_Binary_Num;
        w_Valid_Next      = 1'b0;
        w_Error_Next      = 1'b0;
        w_Blank_Next      = r_Blank;

        if (w_Pattern != r_Seg) begin
            w_Seg_Next   = w_Pattern;
            w_Count_Next = 8'd0;
            w_State_Next = SETTLING;
        end else if (r_State == SETTLING) begin
            if (r_Count < LAST_COUNT) begin
                w_Count_Next = r_Count + 8'd1;
            end else begin
                w_State_Next = LOCKED;
                if (w_Legal) begin
                    w_Binary_Num_Next = w_Value;
                    w_Valid_Next      = 1'b1;
                    w_Blank_Next      = 1'b0;
                end else if (r_Seg == 7'd0) begin
                    w_Blank_Next = 1'b1;
                end else begin
                    w_Error_Next = 1'b1;
                    w_Blank_Next = 1'b0;
                end
            end
        end
    end

    assign o_Binary_Num = r_Binary_Num;
    assign o_Valid      = r_Valid;
    assign o_Error      = r_Error;
    assign o_Blank      = r_Blank;

endmodule
